// File: rtl/axil_pkg.sv
// axil_pkg: response codes and command-entry layout shared by the AXI-Lite write slave
// Entry fields are sized for the widest legal configuration (64-bit address and data);
// narrower instances zero-extend on push and slice on read.
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;
    typedef struct packed {
        logic [MAX_ADDR_W-1:0]   addr;
        logic [MAX_DATA_W-1:0]   data;
        logic [MAX_DATA_W/8-1:0] strb;
        logic                    err;
    } cmd_t;
endpackage

// File: rtl/axil_sync_fifo.sv
// axil_sync_fifo: single-clock FIFO with power-of-two depth
// Ports: clk_i/rst_i (sync active-high), push_i/wdata_i write side, pop_i/rdata_o read
// side (rdata_o shows the head), full_o/empty_o status. Callers never push when full
// or pop when empty.
module axil_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign rdata_o = mem_q[rptr_q];
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + PW'(push_i);
            rptr_q <= rptr_q + PW'(pop_i);
            cnt_q  <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end
endmodule

// File: rtl/axil_write_slave_fifo.sv
// axil_write_slave_fifo: AXI-Lite write slave queueing commands for a backend
// Ports: CLK/RST (sync active-high); AW_* and W_* accepted into one-entry holding
// registers; paired commands queue in a DEPTH-entry FIFO; the backend sees the head via
// DATA_ARRIVE/DATA/DATA_ADDR/DATA_STRB and accepts with DATA_RECIVED; B_* returns one
// response per write in order.
// Build option: define AXIL_WR_RANGE_CHECK_EN to flag writes outside
// [BASE_ADDR, BASE_ADDR+ADDR_SPAN) as SLVERR without reaching the backend.
module axil_write_slave_fifo
    import axil_pkg::*;
#(
    parameter int          ADDR_W    = 64,
    parameter int          DATA_W    = 64,
    parameter int          DEPTH     = 4,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter logic [63:0] ADDR_SPAN = 64'h8000_0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   AW_ADDR,
    input  logic                AW_VALID,
    output logic                AW_READY,
    input  logic [DATA_W-1:0]   W_DATA,
    input  logic [DATA_W/8-1:0] W_STRB,
    input  logic                W_VALID,
    output logic                W_READY,
    output logic [1:0]          B_RESP,
    output logic                B_VALID,
    input  logic                B_READY,
    output logic                DATA_ARRIVE,
    input  logic                DATA_RECIVED,
    output logic [DATA_W-1:0]   DATA,
    output logic [ADDR_W-1:0]   DATA_ADDR,
    output logic [DATA_W/8-1:0] DATA_STRB
);
`ifdef AXIL_WR_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    logic                aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
    logic                b_valid_q, b_valid_d;
    logic [1:0]          b_resp_q, b_resp_d;
    logic                fifo_full, fifo_empty, push, pop, b_free, out_of_range;
    cmd_t                push_cmd, head;
    axil_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .wdata_i (push_cmd),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    assign AW_READY  = !aw_full_q;
    assign W_READY   = !w_full_q;
    assign B_VALID   = b_valid_q;
    assign B_RESP    = b_resp_q;
    assign DATA      = head.data[DATA_W-1:0];
    assign DATA_ADDR = head.addr[ADDR_W-1:0];
    assign DATA_STRB = head.strb[DATA_W/8-1:0];
    always_comb begin
        // Offset form avoids overflow of BASE_ADDR+ADDR_SPAN at the top of the space.
        out_of_range  = (aw_addr_q < ADDR_W'(BASE_ADDR)) ||
                        ((aw_addr_q - ADDR_W'(BASE_ADDR)) >= ADDR_W'(ADDR_SPAN));
        push_cmd      = '0;
        push_cmd.addr = MAX_ADDR_W'(aw_addr_q);
        push_cmd.data = MAX_DATA_W'(w_data_q);
        push_cmd.strb = (MAX_DATA_W/8)'(w_strb_q);
        push_cmd.err  = RANGE_EN && out_of_range;
        push          = aw_full_q && w_full_q && !fifo_full;
        // A response being drained this cycle frees the B register for the next pop.
        b_free        = !b_valid_q || B_READY;
        DATA_ARRIVE   = !fifo_empty && !head.err && b_free;
        pop           = !fifo_empty && b_free && (head.err || DATA_RECIVED);
        aw_full_d     = push ? 1'b0 : (AW_VALID && !aw_full_q) ? 1'b1 : aw_full_q;
        aw_addr_d     = (AW_VALID && !aw_full_q) ? AW_ADDR : aw_addr_q;
        w_full_d      = push ? 1'b0 : (W_VALID && !w_full_q) ? 1'b1 : w_full_q;
        w_data_d      = (W_VALID && !w_full_q) ? W_DATA : w_data_q;
        w_strb_d      = (W_VALID && !w_full_q) ? W_STRB : w_strb_q;
        b_valid_d     = pop ? 1'b1 : B_READY ? 1'b0 : b_valid_q;
        b_resp_d      = pop ? (head.err ? RESP_SLVERR : RESP_OKAY) : b_resp_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
        end
    end
endmodule

// File: tb/tb_axil_write_slave_fifo.sv
// tb_axil_write_slave_fifo: scoreboard bench for the AXI-Lite write slave FIFO
module tb_axil_write_slave_fifo;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SPAN = 64'h1000;
`ifdef AXIL_WR_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    logic        CLK = 1'b0, RST = 1'b1;
    logic [63:0] AW_ADDR = '0, W_DATA = '0, DATA, DATA_ADDR;
    logic [7:0]  W_STRB = '0, DATA_STRB;
    logic        AW_VALID = 1'b0, W_VALID = 1'b0, AW_READY, W_READY;
    logic [1:0]  B_RESP;
    logic        B_VALID, B_READY, DATA_ARRIVE, DATA_RECIVED;
    logic        rand_mode = 1'b0, dr_force = 1'b0, br_force = 1'b1, dr_rand = 1'b0, br_rand = 1'b1;
    int          checks = 0, errors = 0, pops = 0, bresps = 0, p0, b0;
    bit          e;
    typedef struct packed {logic [63:0] a; logic [63:0] d; logic [7:0] s;} ent_t;
    logic [63:0] aw_q[$];
    logic [71:0] w_q[$];
    ent_t        cmd_q[$];
    logic [1:0]  resp_q[$];
    logic [63:0] mon_a, t7_a;
    logic [71:0] mon_w;
    ent_t        mon_e;
    logic [1:0]  mon_r;

    assign DATA_RECIVED = rand_mode ? dr_rand : dr_force;
    assign B_READY      = rand_mode ? br_rand : br_force;

    axil_write_slave_fifo #(
        .ADDR_W(64), .DATA_W(64), .DEPTH(4), .BASE_ADDR(BASE), .ADDR_SPAN(SPAN)
    ) dut (
        .CLK(CLK), .RST(RST),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .DATA_ARRIVE(DATA_ARRIVE), .DATA_RECIVED(DATA_RECIVED),
        .DATA(DATA), .DATA_ADDR(DATA_ADDR), .DATA_STRB(DATA_STRB)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        dr_rand = 1'($urandom_range(0, 1));
        br_rand = ($urandom_range(0, 3) != 0);
    end

    function automatic bit model_err(input logic [63:0] a);
        return RANGE_EN && ((a < BASE) || (a >= BASE + SPAN));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the i-th accepted address pairs with the i-th accepted data beat;
    // each pair yields one response in order, and only error-free pairs reach the backend.
    always @(negedge CLK) begin
        if (RST) begin
            aw_q.delete();
            w_q.delete();
            cmd_q.delete();
            resp_q.delete();
        end else begin
            if (AW_VALID && AW_READY) aw_q.push_back(AW_ADDR);
            if (W_VALID && W_READY) w_q.push_back({W_DATA, W_STRB});
            while (aw_q.size() > 0 && w_q.size() > 0) begin
                mon_a = aw_q.pop_front();
                mon_w = w_q.pop_front();
                if (!model_err(mon_a)) cmd_q.push_back({mon_a, mon_w[71:8], mon_w[7:0]});
                resp_q.push_back(model_err(mon_a) ? 2'b10 : 2'b00);
            end
            if (DATA_ARRIVE && DATA_RECIVED) begin
                pops++;
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL backend_unexpected: got addr %h expected no command", DATA_ADDR);
                end else begin
                    mon_e = cmd_q.pop_front();
                    chk("backend_addr", DATA_ADDR, mon_e.a);
                    chk("backend_data", DATA, mon_e.d);
                    chk("backend_strb", 64'(DATA_STRB), 64'(mon_e.s));
                end
            end
            if (B_VALID && B_READY) begin
                bresps++;
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got resp %h expected no response", B_RESP);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("b_resp", 64'(B_RESP), 64'(mon_r));
                end
            end
            if (B_VALID && !B_READY) chk("arrive_while_b_stalled", 64'(DATA_ARRIVE), 64'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_aw(input logic [63:0] a);
        bit done = 1'b0;
        int n = 0;
        AW_ADDR  = a;
        AW_VALID = 1'b1;
        while (!done) begin
            @(negedge CLK);
            done = AW_READY;
            tick();
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL aw_timeout: got no AW_READY expected handshake within 300 cycles");
                done = 1'b1;
            end
        end
        AW_VALID = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        bit done = 1'b0;
        int n = 0;
        W_DATA  = d;
        W_STRB  = s;
        W_VALID = 1'b1;
        while (!done) begin
            @(negedge CLK);
            done = W_READY;
            tick();
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL w_timeout: got no W_READY expected handshake within 300 cycles");
                done = 1'b1;
            end
        end
        W_VALID = 1'b0;
    endtask

    task automatic send_pair(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((resp_q.size() > 0 || aw_q.size() > 0 || w_q.size() > 0) && n < 600) begin
            tick();
            n++;
        end
        chk("drain_pending", 64'(resp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        at_neg();
        chk("rst_b_valid", 64'(B_VALID), 64'd0);
        chk("rst_b_resp", 64'(B_RESP), 64'd0);
        chk("rst_arrive", 64'(DATA_ARRIVE), 64'd0);
        chk("rst_aw_ready", 64'(AW_READY), 64'd1);
        chk("rst_w_ready", 64'(W_READY), 64'd1);
        tick();
        RST = 1'b0;
        // Same-edge AW/W: command visible two edges later, response one edge after accept.
        dr_force = 1'b1;
        e = model_err(64'h8000_1000);
        AW_ADDR = 64'h8000_1000; AW_VALID = 1'b1;
        W_DATA = 64'hDEADBEEF; W_STRB = 8'hFF; W_VALID = 1'b1;
        at_neg();
        chk("t1_aw_ready", 64'(AW_READY), 64'd1);
        tick();
        AW_VALID = 1'b0; W_VALID = 1'b0;
        at_neg();
        chk("t1_arrive_early", 64'(DATA_ARRIVE), 64'd0);
        tick();
        at_neg();
        chk("t1_arrive", 64'(DATA_ARRIVE), 64'(!e));
        if (!e) begin
            chk("t1_data", DATA, 64'hDEADBEEF);
            chk("t1_addr", DATA_ADDR, 64'h8000_1000);
            chk("t1_strb", 64'(DATA_STRB), 64'hFF);
        end
        tick();
        at_neg();
        chk("t1_b_valid", 64'(B_VALID), 64'd1);
        chk("t1_b_resp", 64'(B_RESP), e ? 64'd2 : 64'd0);
        tick();
        at_neg();
        chk("t1_b_done", 64'(B_VALID), 64'd0);
        // W leads AW by three cycles.
        tick();
        e = model_err(64'h8000_0040);
        W_DATA = 64'h0123_4567_89AB_CDEF; W_STRB = 8'h0F; W_VALID = 1'b1;
        AW_ADDR = 64'h8000_0040;
        tick();
        W_VALID = 1'b0;
        at_neg();
        chk("t2_w_ready_0", 64'(W_READY), 64'd0);
        tick();
        at_neg();
        chk("t2_w_ready_1", 64'(W_READY), 64'd0);
        tick();
        AW_VALID = 1'b1;
        at_neg();
        chk("t2_w_ready_2", 64'(W_READY), 64'd0);
        chk("t2_aw_ready", 64'(AW_READY), 64'd1);
        tick();
        AW_VALID = 1'b0;
        at_neg();
        chk("t2_arrive_early", 64'(DATA_ARRIVE), 64'd0);
        tick();
        at_neg();
        chk("t2_arrive", 64'(DATA_ARRIVE), 64'(!e));
        chk("t2_w_ready_free", 64'(W_READY), 64'd1);
        if (!e) chk("t2_data", DATA, 64'h0123_4567_89AB_CDEF);
        tick();
        at_neg();
        chk("t2_b_valid", 64'(B_VALID), 64'd1);
        wait_drain();
        // Backend stalled: FIFO fills, holding registers fill, READY drops.
        dr_force = 1'b0;
        b0 = bresps;
        p0 = pops;
        fork
            for (int i = 0; i < 6; i++)
                send_pair(BASE + 64'h100 + 64'(i * 8), {$urandom, $urandom}, 8'hFF);
            begin
                repeat (20) tick();
                at_neg();
                chk("t3_aw_ready", 64'(AW_READY), 64'd0);
                chk("t3_w_ready", 64'(W_READY), 64'd0);
                chk("t3_arrive", 64'(DATA_ARRIVE), 64'd1);
                chk("t3_no_pops", 64'(pops - p0), 64'd0);
                chk("t3_accepted", 64'(resp_q.size()), 64'd5);
                tick();
                dr_force = 1'b1;
            end
        join
        wait_drain();
        chk("t3_bresps", 64'(bresps - b0), 64'd6);
        // Out-of-window write followed by an in-window write.
        b0 = bresps;
        send_pair(64'h0, 64'h1111_2222_3333_4444, 8'h00);
        send_pair(BASE + 64'h200, 64'h5555_6666_7777_8888, 8'h3C);
        wait_drain();
        chk("t4_bresps", 64'(bresps - b0), 64'd2);
        // B channel stalled with three writes pending.
        br_force = 1'b0;
        p0 = pops;
        b0 = bresps;
        for (int i = 0; i < 3; i++) send_pair(BASE + 64'h300 + 64'(i * 8), {$urandom, $urandom}, 8'hA5);
        repeat (15) tick();
        at_neg();
        chk("t5_b_valid", 64'(B_VALID), 64'd1);
        chk("t5_one_pop", 64'(pops - p0), 64'd1);
        chk("t5_arrive", 64'(DATA_ARRIVE), 64'd0);
        tick();
        br_force = 1'b1;
        wait_drain();
        chk("t5_pops", 64'(pops - p0), 64'd3);
        chk("t5_bresps", 64'(bresps - b0), 64'd3);
        // Reset with two entries queued.
        dr_force = 1'b0;
        send_pair(BASE + 64'h400, 64'hAAAA, 8'hFF);
        send_pair(BASE + 64'h408, 64'hBBBB, 8'hFF);
        repeat (5) tick();
        at_neg();
        chk("t6_pre_arrive", 64'(DATA_ARRIVE), 64'd1);
        tick();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        at_neg();
        chk("t6_b_valid", 64'(B_VALID), 64'd0);
        chk("t6_arrive", 64'(DATA_ARRIVE), 64'd0);
        chk("t6_aw_ready", 64'(AW_READY), 64'd1);
        chk("t6_w_ready", 64'(W_READY), 64'd1);
        tick();
        dr_force = 1'b1;
        b0 = bresps;
        send_pair(BASE + 64'h500, 64'hCAFE_F00D, 8'h0F);
        wait_drain();
        chk("t6_bresps", 64'(bresps - b0), 64'd1);
        // Randomized independent AW/W streams with random backend and B backpressure.
        rand_mode = 1'b1;
        b0 = bresps;
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                t7_a = ($urandom_range(0, 3) != 0) ? BASE + 64'($urandom_range(0, 4095)) : {32'h0, $urandom};
                send_aw(t7_a);
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                send_w({$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));
            end
        join
        rand_mode = 1'b0;
        dr_force = 1'b1;
        br_force = 1'b1;
        wait_drain();
        chk("t7_bresps", 64'(bresps - b0), 64'd40);
        chk("t7_cmd_empty", 64'(cmd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
